// File: rtl/poly_result_capture_if.sv
// Handshake and readback bundle between the POLY_MAU result stage and its driver.
// master drives the arm/capture/read requests; slave is the capture block itself.
interface poly_result_capture_if #(
    parameter int DW    = 24,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          start;
    logic          clr;
    logic          mau_valid;
    logic [DW-1:0] mau_o0;
    logic [DW-1:0] mau_o1;
    logic          rd_en;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          busy;
    logic          cap_pulse;
    logic [7:0]    latency;
    logic [CW-1:0] fifo_cnt;
    logic          timeout_err;
    logic          overflow;
    logic          stray_valid;
    logic          underflow;

    modport master (
        output start, clr, mau_valid, mau_o0, mau_o1, rd_en,
        input  rd_data, rd_valid, busy, cap_pulse, latency, fifo_cnt,
               timeout_err, overflow, stray_valid, underflow
    );

    modport slave (
        input  start, clr, mau_valid, mau_o0, mau_o1, rd_en,
        output rd_data, rd_valid, busy, cap_pulse, latency, fifo_cnt,
               timeout_err, overflow, stray_valid, underflow
    );
endinterface

// File: rtl/poly_result_capture.sv
// Captures {o1,o0} from the MAU after each armed run, queues it, and serialises
// each 48-bit result as three 16-bit words, with latency and error flags for tracing.
module poly_result_capture #(
    parameter int DW      = 24,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    poly_result_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    tmr;
    logic [7:0]    tmr_next;
    logic          capture;
    logic          timeout_hit;
    logic          stray;

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [1:0]      wptr;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [DW-1:0]   head_o0;
    logic [DW-1:0]   head_o1;
    logic [15:0]     word;

    logic [15:0]     rd_data_q;
    logic            rd_valid_q;
    logic [7:0]      latency_q;
    logic            timeout_q;
    logic            overflow_q;
    logic            stray_q;
    logic            underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // A second start while waiting is deliberately ignored so the timer measures the first arm.
    always_comb begin
        state_next  = state;
        tmr_next    = tmr;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        stray       = 1'b0;
        case (state)
            S_IDLE: begin
                stray = bus.mau_valid;
                if (bus.start) begin
                    state_next = S_WAIT;
                    tmr_next   = '0;
                end
            end
            S_WAIT: begin
                tmr_next = tmr + 8'd1;
                if (bus.mau_valid) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else if (tmr == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = bus.rd_en && !empty && (wptr == 2'd2);
    // A same-cycle pop frees the head slot, so a full FIFO can still accept the push.
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign head_o0 = mem[rd_ptr][DW-1:0];
    assign head_o1 = mem[rd_ptr][2*DW-1:DW];

    // Word layout assumes DW=24: the 48-bit result split low-to-high into three halves.
    always_comb begin
        word = 16'h0000;
        case (wptr)
            2'd0:    word = head_o0[15:0];
            2'd1:    word = {head_o1[7:0], head_o0[23:16]};
            2'd2:    word = head_o1[23:8];
            default: word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !bus.clr) begin
            mem[wr_ptr] <= {bus.mau_o1, bus.mau_o0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wptr        <= 2'd0;
            rd_data_q   <= 16'h0000;
            rd_valid_q  <= 1'b0;
            latency_q   <= 8'd0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wptr        <= 2'd0;
            rd_data_q   <= 16'h0000;
            rd_valid_q  <= 1'b0;
            latency_q   <= 8'd0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (empty) begin
                    rd_data_q   <= 16'h0000;
                    underflow_q <= 1'b1;
                end else begin
                    rd_data_q <= word;
                    wptr      <= pop ? 2'd0 : wptr + 2'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture) begin
                latency_q <= tmr + 8'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (stray) begin
                stray_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.busy        = (state == S_WAIT);
    assign bus.cap_pulse   = capture;
    assign bus.latency     = latency_q;
    assign bus.fifo_cnt    = count;
    assign bus.timeout_err = timeout_q;
    assign bus.overflow    = overflow_q;
    assign bus.stray_valid = stray_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_poly_result_capture.sv
// Directed scenarios plus a random run, all checked cycle by cycle against a
// queue-based model that derives latency and timeout from edge counts.
module tb_poly_result_capture;
    localparam int DW      = 24;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_result_capture_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    poly_result_capture #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [47:0] q[$];
    int          wsel;
    bit          waiting;
    int          start_cyc;
    int          cyc;
    bit          m_timeout, m_overflow, m_stray, m_underflow;
    int          m_latency;
    logic [15:0] m_rd_data;
    bit          m_rd_valid;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wsel        = 0;
        waiting     = 0;
        start_cyc   = 0;
        m_timeout   = 0;
        m_overflow  = 0;
        m_stray     = 0;
        m_underflow = 0;
        m_latency   = 0;
        m_rd_data   = 16'h0000;
        m_rd_valid  = 0;
    endtask

    task automatic check_model();
        check_output("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        check_output("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
        check_output("latency", 32'(bus.latency), 32'(m_latency));
        check_output("fifo_cnt", 32'(bus.fifo_cnt), 32'(q.size()));
        check_output("busy", 32'(bus.busy), 32'(waiting));
        check_output("timeout_err", 32'(bus.timeout_err), 32'(m_timeout));
        check_output("overflow", 32'(bus.overflow), 32'(m_overflow));
        check_output("stray_valid", 32'(bus.stray_valid), 32'(m_stray));
        check_output("underflow", 32'(bus.underflow), 32'(m_underflow));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
        check_output({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
        check_output({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check_output({tag, "_cap_pulse"}, 32'(bus.cap_pulse), 32'h0);
        check_output({tag, "_latency"}, 32'(bus.latency), 32'h0);
        check_output({tag, "_fifo_cnt"}, 32'(bus.fifo_cnt), 32'h0);
        check_output({tag, "_flags"}, 32'({bus.timeout_err, bus.overflow, bus.stray_valid, bus.underflow}), 32'h0);
    endtask

    // One clock of stimulus: combinational outputs are checked before the edge, registered ones after.
    task automatic apply_stimulus(input bit st, input bit vl, input logic [23:0] o0,
                                  input logic [23:0] o1, input bit rd, input bit cl);
        bit cap, tmo, was_waiting, pop;
        bus.start     = st;
        bus.mau_valid = vl;
        bus.mau_o0    = o0;
        bus.mau_o1    = o1;
        bus.rd_en     = rd;
        bus.clr       = cl;
        #1;
        check_output("busy_pre", 32'(bus.busy), 32'(waiting));
        check_output("cap_pulse", 32'(bus.cap_pulse), 32'(waiting && vl));
        @(posedge clk);
        cyc++;
        was_waiting = waiting;
        cap = 0;
        tmo = 0;
        if (waiting) begin
            if (vl) begin
                cap = 1;
                waiting = 0;
            end else if (cyc - start_cyc == TIMEOUT) begin
                tmo = 1;
                waiting = 0;
            end
        end else if (st) begin
            waiting = 1;
            start_cyc = cyc;
        end
        if (cl) begin
            q.delete();
            wsel        = 0;
            m_timeout   = 0;
            m_overflow  = 0;
            m_stray     = 0;
            m_underflow = 0;
            m_latency   = 0;
            m_rd_data   = 16'h0000;
            m_rd_valid  = 0;
        end else begin
            m_rd_valid = rd;
            pop = 0;
            if (rd) begin
                if (q.size() == 0) begin
                    m_rd_data   = 16'h0000;
                    m_underflow = 1;
                end else begin
                    m_rd_data = 16'(q[0] >> (16 * wsel));
                    if (wsel == 2) begin
                        pop  = 1;
                        wsel = 0;
                    end else begin
                        wsel++;
                    end
                end
            end
            if (pop) q.delete(0);
            if (cap) begin
                m_latency = cyc - start_cyc;
                if (q.size() < DEPTH) q.push_back({o1, o0});
                else m_overflow = 1;
            end
            if (tmo) m_timeout = 1;
            if (!was_waiting && vl) m_stray = 1;
        end
        #1;
        check_model();
    endtask

    task automatic idle_step();
        apply_stimulus(0, 0, 24'h0, 24'h0, 0, 0);
    endtask

    task automatic read_step();
        apply_stimulus(0, 0, 24'h0, 24'h0, 1, 0);
    endtask

    task automatic clr_step();
        apply_stimulus(0, 0, 24'h0, 24'h0, 0, 1);
    endtask

    initial begin
        logic [23:0] o0, o1;
        bus.start = 0; bus.clr = 0; bus.mau_valid = 0;
        bus.mau_o0 = '0; bus.mau_o1 = '0; bus.rd_en = 0;
        cyc = 0;
        model_reset();
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: latency 3 and serialised readback.
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        idle_step();
        idle_step();
        apply_stimulus(0, 1, 24'h123456, 24'hABCDEF, 0, 0);
        check_output("t1_latency", 32'(bus.latency), 32'd3);
        check_output("t1_fifo_cnt", 32'(bus.fifo_cnt), 32'd1);
        read_step();
        check_output("t1_w0", 32'(bus.rd_data), 32'h3456);
        read_step();
        check_output("t1_w1", 32'(bus.rd_data), 32'hEF12);
        read_step();
        check_output("t1_w2", 32'(bus.rd_data), 32'hABCD);
        check_output("t1_empty", 32'(bus.fifo_cnt), 32'd0);

        // Scenario 2: timeout exactly TIMEOUT edges after start.
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        repeat (TIMEOUT - 1) idle_step();
        check_output("t2_not_yet", 32'(bus.timeout_err), 32'd0);
        check_output("t2_busy", 32'(bus.busy), 32'd1);
        idle_step();
        check_output("t2_timeout", 32'(bus.timeout_err), 32'd1);
        check_output("t2_idle", 32'(bus.busy), 32'd0);
        check_output("t2_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        clr_step();

        // Scenario 3: five captures into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
            apply_stimulus(0, 1, {8'h3C, 16'(16'hA000 + i)}, {16'(16'hB000 + i), 8'h5D}, 0, 0);
        end
        check_output("t3_fifo_cnt", 32'(bus.fifo_cnt), 32'd4);
        check_output("t3_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            read_step();
            check_output("t3_w0", 32'(bus.rd_data), 32'(16'hA000 + i));
            read_step();
            check_output("t3_w1", 32'(bus.rd_data), 32'h5D3C);
            read_step();
            check_output("t3_w2", 32'(bus.rd_data), 32'(16'hB000 + i));
        end
        check_output("t3_drained", 32'(bus.fifo_cnt), 32'd0);
        clr_step();

        // Scenario 4: full FIFO, head pop coincides with a new capture.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
            apply_stimulus(0, 1, {8'h3C, 16'(16'hA000 + i)}, {16'(16'hB000 + i), 8'h5D}, 0, 0);
        end
        read_step();
        read_step();
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        apply_stimulus(0, 1, 24'h777777, 24'h888888, 1, 0);
        check_output("t4_w2", 32'(bus.rd_data), 32'hB000);
        check_output("t4_fifo_cnt", 32'(bus.fifo_cnt), 32'd4);
        check_output("t4_overflow", 32'(bus.overflow), 32'd0);
        repeat (12) read_step();
        check_output("t4_tail_w2", 32'(bus.rd_data), 32'h8888);
        clr_step();

        // Scenario 5: stray valid and underflow.
        apply_stimulus(0, 1, 24'h111111, 24'h222222, 0, 0);
        check_output("t5_stray", 32'(bus.stray_valid), 32'd1);
        check_output("t5_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        read_step();
        check_output("t5_rd_data", 32'(bus.rd_data), 32'h0);
        check_output("t5_underflow", 32'(bus.underflow), 32'd1);
        clr_step();

        // Scenario 6: async reset in WAIT with a half-read entry queued.
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        apply_stimulus(0, 1, 24'h445566, 24'h112233, 0, 0);
        read_step();
        read_step();
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        bus.start = 0; bus.rd_en = 0; bus.mau_valid = 0; bus.clr = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1, 0, 24'h0, 24'h0, 0, 0);
        apply_stimulus(0, 1, 24'hC0FFEE, 24'hFACADE, 0, 0);
        read_step();
        check_output("t6_w0", 32'(bus.rd_data), 32'hFFEE);
        read_step();
        read_step();
        check_output("t6_w2", 32'(bus.rd_data), 32'hFACA);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            o0 = 24'($urandom);
            o1 = 24'($urandom);
            apply_stimulus(($urandom_range(3) == 0), ($urandom_range(4) == 0), o0, o1,
                           ($urandom_range(2) == 0), ($urandom_range(59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
